eth_rx_frame_buffer: RTL and testbench

ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

---
 rtl/eth_pkg.sv | 15 +
 rtl/sync_2ff.sv | 28 ++
 rtl/eth_rx_frame_buffer.sv | 184 ++++++++++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and default sizing for the Ethernet receive frame buffer.
`timescale 1ns/1ps
package eth_pkg;

   localparam int unsigned DefAw     = 11;
   localparam int unsigned DefMinLen = 60;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StReady,
      StDrop
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset level.
`timescale 1ns/1ps
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops to resolve metastability on the async input.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Single-frame receive buffer between the SPI receiver stage and the CPU.
// Optional build macro: ETH_RX_RUNT_DROP_EN drops frames shorter than MIN_LEN.
`timescale 1ns/1ps
module eth_rx_frame_buffer
   import eth_pkg::*;
#(
   parameter int unsigned AW      = DefAw,
   parameter int unsigned MIN_LEN = DefMinLen
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic [7:0]    recv_d,
   input  logic [AW-1:0] recv_a,
   input  logic          n_recv_buf_we,
   input  logic          recv_ena,
   input  logic [AW-1:0] cpu_a,
   input  logic          cpu_rd,
   output logic [7:0]    cpu_d,
   input  logic          cpu_ack,
   output logic          frame_ready,
   output logic [AW:0]   frame_len,
   output logic          overrun
);

   localparam int unsigned Depth   = 2 ** AW;
   localparam logic [AW:0] CntFull = {1'b1, {AW{1'b0}}};

   logic          we_s;
   logic          ena_s;
   logic          we_prev_q;
   logic          ena_prev_q;
   logic [1:0]    settle_q;
   logic          settled;
   logic          wr_fall;
   logic          ena_rise;
   logic          ena_fall;
   logic          wr_ok;
   logic          ovf;
   logic          runt;
   logic [AW:0]   cnt_inc;

   rx_state_t     state_q, state_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   len_q, len_d;
   logic          ready_q, ready_d;
   logic          ovr_q, ovr_d;
   logic [7:0]    cpu_d_q;
   logic [7:0]    mem [Depth];

   sync_2ff #(.RST_VAL(1'b1)) u_sync_we (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (n_recv_buf_we),
      .q     (we_s)
   );

   sync_2ff #(.RST_VAL(1'b0)) u_sync_ena (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (recv_ena),
      .q     (ena_s)
   );

   // Edge history; edges are ignored until the synchronizers have refilled after reset,
   // so a recv_ena still high across reset release is not mistaken for a new frame.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         we_prev_q  <= 1'b1;
         ena_prev_q <= 1'b0;
         settle_q   <= 2'd0;
      end else begin
         we_prev_q  <= we_s;
         ena_prev_q <= ena_s;
         if (!settled) begin
            settle_q <= settle_q + 2'd1;
         end
      end
   end

   assign settled  = (settle_q == 2'd3);
   assign wr_fall  = settled & we_prev_q & ~we_s;
   assign ena_rise = settled & ~ena_prev_q & ena_s;
   assign ena_fall = settled & ena_prev_q & ~ena_s;

   assign wr_ok   = (state_q == StRecv) & wr_fall & (cnt_q != CntFull);
   assign ovf     = (state_q == StRecv) & wr_fall & (cnt_q == CntFull);
   assign cnt_inc = cnt_q + {{AW{1'b0}}, wr_ok};

`ifdef ETH_RX_RUNT_DROP_EN
   assign runt = (32'(cnt_inc) < MIN_LEN);
`else
   assign runt = 1'b0;
`endif

   // Frame FSM next-state and frame bookkeeping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ready_d = ready_q;
      ovr_d   = ovr_q;
      unique case (state_q)
         StIdle: begin
            if (ena_rise) begin
               state_d = StRecv;
               cnt_d   = '0;
            end
         end
         StRecv: begin
            cnt_d = cnt_inc;
            if (ovf) begin
               state_d = StDrop;
               ovr_d   = 1'b1;
            end
            if (ena_fall) begin
               if (ovf || (cnt_inc == '0) || runt) begin
                  state_d = StIdle;
               end else begin
                  state_d = StReady;
                  len_d   = cnt_inc;
                  ready_d = 1'b1;
               end
            end
         end
         StReady: begin
            if (cpu_ack) begin
               // Ack wins over a coinciding new frame: release and start receiving.
               ready_d = 1'b0;
               ovr_d   = 1'b0;
               cnt_d   = '0;
               state_d = ena_rise ? StRecv : StIdle;
            end else if (ena_rise) begin
               state_d = StDrop;
               ovr_d   = 1'b1;
            end
         end
         StDrop: begin
            if (ena_fall) begin
               state_d = ready_q ? StReady : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM and frame status registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         len_q   <= '0;
         ready_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ready_q <= ready_d;
         ovr_q   <= ovr_d;
      end
   end

   // Buffer storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[recv_a] <= recv_d;
      end
   end

   // Registered CPU read port, holds its value between reads.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cpu_d_q <= 8'h00;
      end else if (cpu_rd) begin
         cpu_d_q <= mem[cpu_a];
      end
   end

   assign cpu_d       = cpu_d_q;
   assign frame_ready = ready_q;
   assign frame_len   = len_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Self-checking bench for eth_rx_frame_buffer against a frame-level reference model.
`timescale 1ns/1ps
module tb_eth_rx_frame_buffer;
   import eth_pkg::*;

   localparam int unsigned AW      = DefAw;
   localparam int unsigned Depth   = 1 << AW;
   localparam int unsigned MIN_LEN = DefMinLen;

   logic          clk = 1'b0;
   logic          n_rst;
   logic [7:0]    recv_d;
   logic [AW-1:0] recv_a;
   logic          n_recv_buf_we;
   logic          recv_ena;
   logic [AW-1:0] cpu_a;
   logic          cpu_rd;
   logic [7:0]    cpu_d;
   logic          cpu_ack;
   logic          frame_ready;
   logic [AW:0]   frame_len;
   logic          overrun;

   eth_rx_frame_buffer #(.AW(AW), .MIN_LEN(MIN_LEN)) dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .recv_d        (recv_d),
      .recv_a        (recv_a),
      .n_recv_buf_we (n_recv_buf_we),
      .recv_ena      (recv_ena),
      .cpu_a         (cpu_a),
      .cpu_rd        (cpu_rd),
      .cpu_d         (cpu_d),
      .cpu_ack       (cpu_ack),
      .frame_ready   (frame_ready),
      .frame_len     (frame_len),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   bit chk_en     = 1'b0;

   // Reference model: buffer image plus frame-level status.
   logic [7:0] m_mem [Depth];
   bit         m_wr  [Depth];
   int         wr_list[$];
   bit         m_held = 1'b0;
   int         m_len  = 0;
   bit         m_ovr  = 1'b0;
   logic [7:0] m_cpu_d = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_runt(input int n);
`ifdef ETH_RX_RUNT_DROP_EN
      return n < int'(MIN_LEN);
`else
      return n < 0;
`endif
   endfunction

   // Continuous comparison of all outputs against the model while they are settled.
   always @(negedge clk) begin
      if (chk_en) begin
         check("frame_ready", 32'(frame_ready), 32'(m_held));
         check("frame_len", 32'(frame_len), 32'(m_len));
         check("overrun", 32'(overrun), 32'(m_ovr));
         check("cpu_d", 32'(cpu_d), 32'(m_cpu_d));
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input int a, input logic [7:0] d);
      recv_a        = AW'(a);
      recv_d        = d;
      n_recv_buf_we = 1'b0;
      clks(5);
      n_recv_buf_we = 1'b1;
      clks(4);
   endtask

   task automatic cpu_read(input int a);
      cpu_a  = AW'(a);
      cpu_rd = 1'b1;
      @(posedge clk);
      #1;
      cpu_rd  = 1'b0;
      m_cpu_d = m_mem[a];
   endtask

   task automatic do_ack();
      chk_en  = 1'b0;
      cpu_ack = 1'b1;
      clks(1);
      cpu_ack = 1'b0;
      clks(2);
      if (m_held) begin
         m_held = 1'b0;
         m_ovr  = 1'b0;
      end
      chk_en = 1'b1;
   endtask

   // One whole frame of n bytes at base..base+n-1 (wrapping); optional ack aligned to the
   // clock in which the synchronized recv_ena rise is seen.
   task automatic send_frame(input int n, input int base, input bit incr, input bit ack_rise);
      bit accept;
      bit dropped;
      int cnt;
      int a;
      logic [7:0] d;
      chk_en   = 1'b0;
      recv_ena = 1'b1;
      if (ack_rise) begin
         clks(2);
         cpu_ack = 1'b1;
         clks(1);
         cpu_ack = 1'b0;
         clks(2);
         m_held = 1'b0;
         m_ovr  = 1'b0;
      end else begin
         clks(5);
      end
      accept = !m_held;
      if (!accept) m_ovr = 1'b1;
      chk_en  = 1'b1;
      cnt     = 0;
      dropped = 1'b0;
      for (int i = 0; i < n; i++) begin
         a = (base + i) % Depth;
         d = incr ? 8'(i) : 8'($urandom);
         if (accept && !dropped && cnt == int'(Depth)) chk_en = 1'b0;
         write_byte(a, d);
         if (accept && !dropped) begin
            if (cnt == int'(Depth)) begin
               dropped = 1'b1;
               m_ovr   = 1'b1;
            end else begin
               m_mem[a] = d;
               if (!m_wr[a]) wr_list.push_back(a);
               m_wr[a] = 1'b1;
               cnt++;
            end
         end
         chk_en = 1'b1;
      end
      clks(2);
      chk_en   = 1'b0;
      recv_ena = 1'b0;
      clks(6);
      if (accept && !dropped && cnt > 0 && !is_runt(cnt)) begin
         m_held = 1'b1;
         m_len  = cnt;
      end
      chk_en = 1'b1;
      clks(1);
   endtask

   task automatic random_reads(input int k);
      for (int i = 0; i < k; i++) begin
         if (wr_list.size() > 0) begin
            cpu_read(wr_list[$urandom_range(0, wr_list.size() - 1)]);
            clks(1);
         end
      end
   endtask

   initial begin
      n_rst         = 1'b0;
      recv_d        = 8'h00;
      recv_a        = '0;
      n_recv_buf_we = 1'b1;
      recv_ena      = 1'b0;
      cpu_a         = '0;
      cpu_rd        = 1'b0;
      cpu_ack       = 1'b0;
      clks(3);
      n_rst = 1'b1;
      clks(4);
      check("reset frame_ready", 32'(frame_ready), 32'd0);
      check("reset frame_len", 32'(frame_len), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset cpu_d", 32'(cpu_d), 32'd0);
      chk_en = 1'b1;

      // 64-byte frame 0x00..0x3F.
      send_frame(64, 0, 1'b1, 1'b0);
      check("frame64 ready", 32'(frame_ready), 32'd1);
      check("frame64 len", 32'(frame_len), 32'd64);
      cpu_read(16);
      check("read 0x10", 32'(cpu_d), 32'h10);
      clks(3);
      check("cpu_d hold", 32'(cpu_d), 32'h10);

      // Second frame while held: overrun, held bytes untouched.
      send_frame(30, 0, 1'b0, 1'b0);
      check("overrun set", 32'(overrun), 32'd1);
      check("held len", 32'(frame_len), 32'd64);
      cpu_read(16);
      check("held byte", 32'(cpu_d), 32'h10);
      do_ack();
      check("ack ready", 32'(frame_ready), 32'd0);
      check("ack overrun", 32'(overrun), 32'd0);

      // Short frame.
      send_frame(20, 100, 1'b1, 1'b0);
`ifdef ETH_RX_RUNT_DROP_EN
      check("runt ready", 32'(frame_ready), 32'd0);
`else
      check("short len", 32'(frame_len), 32'd20);
`endif
      do_ack();

      // Frame with no writes.
      send_frame(0, 0, 1'b0, 1'b0);
      check("empty ready", 32'(frame_ready), 32'd0);

      // 2049 writes: one past capacity.
      send_frame(2049, 0, 1'b0, 1'b0);
      check("oversize ready", 32'(frame_ready), 32'd0);
      check("oversize overrun", 32'(overrun), 32'd1);

      // Held frame, then ack coinciding with the next frame start.
      send_frame(64, 500, 1'b1, 1'b0);
      send_frame(70, 900, 1'b0, 1'b1);
      check("ack+rise overrun", 32'(overrun), 32'd0);
      check("ack+rise len", 32'(frame_len), 32'd70);
      do_ack();

      // Reset part-way through a frame, recv_ena held high across release.
      chk_en   = 1'b0;
      recv_ena = 1'b1;
      clks(5);
      for (int i = 0; i < 10; i++) begin
         write_byte(1200 + i, 8'(8'hA0 + i));
         m_mem[1200 + i] = 8'(8'hA0 + i);
         if (!m_wr[1200 + i]) wr_list.push_back(1200 + i);
         m_wr[1200 + i] = 1'b1;
      end
      n_rst = 1'b0;
      clks(2);
      n_rst   = 1'b1;
      m_held  = 1'b0;
      m_len   = 0;
      m_ovr   = 1'b0;
      m_cpu_d = 8'h00;
      clks(1);
      check("rst frame_ready", 32'(frame_ready), 32'd0);
      check("rst frame_len", 32'(frame_len), 32'd0);
      check("rst overrun", 32'(overrun), 32'd0);
      check("rst cpu_d", 32'(cpu_d), 32'd0);
      chk_en = 1'b1;
      for (int i = 0; i < 3; i++) write_byte(1300 + i, 8'h55);
      recv_ena = 1'b0;
      chk_en   = 1'b0;
      clks(6);
      chk_en = 1'b1;
      check("rst discard", 32'(frame_ready), 32'd0);
      send_frame(64, 1400, 1'b1, 1'b0);
      check("post-rst len", 32'(frame_len), 32'd64);
      random_reads(4);
      do_ack();

      // Randomized traffic.
      for (int it = 0; it < 20; it++) begin
         send_frame($urandom_range(0, 90), $urandom_range(0, Depth - 1), 1'b0,
                    ($urandom_range(0, 9) == 0));
         random_reads(3);
         if ($urandom_range(0, 9) < 6) do_ack();
      end

      chk_en = 1'b0;
      clks(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
